conj_demod_mc: RTL and testbench

//  Multi-channel, pipelined conjugate-product FM discriminator: y[n] = x[n]*conj(x[n-1]) per channel.

---
 rtl/conj_demod_pkg.sv | 46 ++++
 rtl/conj_demod_mc_if.sv | 13 +
 rtl/conj_demod_mc_cplx_conj_mult.sv | 77 +++++++
 rtl/conj_demod_mc.sv | 102 ++++++++++
 tb/tb_conj_demod_mc.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conj_demod_pkg.sv
// Shared IQ pair type and the round/shift/narrow helper for the conjugate discriminator.
// Build option CONJ_DEMOD_SAT_EN: clamp to the output range instead of two's-complement wrap.
package conj_demod_pkg;

  localparam int MAX_W  = 32;
  localparam int PROD_W = 2 * MAX_W;
  localparam int SUM_W  = PROD_W + 1;

  typedef struct packed {
    logic signed [MAX_W-1:0] q;
    logic signed [MAX_W-1:0] i;
  } iq_t;

  // Round half toward +inf, arithmetic shift, then saturate or leave for the caller to wrap.
  function automatic logic signed [SUM_W:0] scale_narrow(input logic signed [SUM_W-1:0] sum,
                                                         input int shift,
                                                         input int out_w);
    logic signed [SUM_W:0] v;
    logic signed [SUM_W:0] rnd;
`ifdef CONJ_DEMOD_SAT_EN
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
`endif
    rnd = (shift > 0) ? ((SUM_W+1)'(1) <<< (shift - 1)) : '0;
    v   = ($signed({sum[SUM_W-1], sum}) + rnd) >>> shift;
`ifdef CONJ_DEMOD_SAT_EN
    hi = ((SUM_W+1)'(1) <<< (out_w - 1)) - (SUM_W+1)'(1);
    lo = ~hi;
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end else begin
      v = v;
    end
`else
    if (out_w < 1) begin
      v = '0;
    end else begin
      v = v;
    end
`endif
    return v;
  endfunction

endpackage

// File: rtl/conj_demod_mc_if.sv
// AXI-Stream style beat bundle shared by the input and output sides of conj_demod_mc.
interface conj_demod_mc_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [DATA_W/8-1:0] tstrb;

  modport master (output tvalid, output tdata, output tlast, output tstrb, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tstrb, output tready);
endinterface

// File: rtl/conj_demod_mc_cplx_conj_mult.sv
// Two-stage a*conj(b): S2 registers the four partial products, S3 registers the scaled,
// narrowed complex result together with its valid/last/strobe.
module cplx_conj_mult
  import conj_demod_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  in_hv,
  input  logic                  in_last,
  input  iq_t                   a,
  input  iq_t                   b,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [2*OUT_W-1:0]    out_data,
  output logic [2*OUT_W/8-1:0]  out_strb
);

  logic signed [PROD_W-1:0] ac_r, bd_r, bc_r, ad_r;
  logic                     valid2_r, hv2_r, last2_r;
  logic signed [SUM_W-1:0]  re_sum_s, im_sum_s;
  logic [OUT_W-1:0]         re_s, im_s;

  // S2: partial products of cur (a) against the channel history (b)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_r     <= '0;
      bd_r     <= '0;
      bc_r     <= '0;
      ad_r     <= '0;
      valid2_r <= 1'b0;
      hv2_r    <= 1'b0;
      last2_r  <= 1'b0;
    end else if (en) begin
      ac_r     <= $signed(a.i) * $signed(b.i);
      bd_r     <= $signed(a.q) * $signed(b.q);
      bc_r     <= $signed(a.q) * $signed(b.i);
      ad_r     <= $signed(a.i) * $signed(b.q);
      valid2_r <= in_valid;
      hv2_r    <= in_hv;
      last2_r  <= in_last;
    end
  end

  // Sum, scale and narrow; a beat without history yields zero
  always_comb begin
    re_sum_s = {ac_r[PROD_W-1], ac_r} + {bd_r[PROD_W-1], bd_r};
    im_sum_s = {bc_r[PROD_W-1], bc_r} - {ad_r[PROD_W-1], ad_r};
    if (hv2_r) begin
      re_s = OUT_W'(scale_narrow(re_sum_s, SHIFT, OUT_W));
      im_s = OUT_W'(scale_narrow(im_sum_s, SHIFT, OUT_W));
    end else begin
      re_s = '0;
      im_s = '0;
    end
  end

  // S3: output register, held while the downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
    end else if (en) begin
      out_valid <= valid2_r;
      out_last  <= last2_r;
      out_data  <= {im_s, re_s};
      out_strb  <= valid2_r ? '1 : '0;
    end
  end

endmodule

// File: rtl/conj_demod_mc.sv
// Multi-channel conjugate-product FM discriminator y[n] = x[n]*conj(x[n-1]) per channel.
// Optional build macro CONJ_DEMOD_SAT_EN selects saturating narrowing (see conj_demod_pkg).
module conj_demod_mc
  import conj_demod_pkg::*;
#(
  parameter int IQ_W   = 16,
  parameter int OUT_W  = 16,
  parameter int NUM_CH = 1,
  parameter int SHIFT  = 15,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input logic               s00_axis_aclk,
  input logic               s00_axis_aresetn,
  conj_demod_mc_if.slave    s00_axis,
  conj_demod_mc_if.master   m00_axis
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (C_S00_AXIS_TDATA_WIDTH != 2 * IQ_W) begin : g_bad_s_width
    $error("C_S00_AXIS_TDATA_WIDTH must equal 2*IQ_W");
  end
  if (C_M00_AXIS_TDATA_WIDTH != 2 * OUT_W) begin : g_bad_m_width
    $error("C_M00_AXIS_TDATA_WIDTH must equal 2*OUT_W");
  end

  logic              en_s, acc_s, m_valid_s;
  iq_t               cur_s;
  iq_t               hist_r [NUM_CH];
  logic [NUM_CH-1:0] hv_r;
  logic [CH_W-1:0]   ch_r;
  iq_t               cur1_r, prev1_r;
  logic              v1_r, hv1_r, last1_r;

  // One enable stalls every stage together; no bubbles while the sink keeps up
  assign en_s            = !m_valid_s || m00_axis.tready;
  assign acc_s           = s00_axis.tvalid && en_s;
  assign s00_axis.tready = en_s;
  assign m00_axis.tvalid = m_valid_s;

  // Unpack the input beat into sign-extended I/Q
  always_comb begin
    cur_s.i = MAX_W'($signed(s00_axis.tdata[IQ_W-1:0]));
    cur_s.q = MAX_W'($signed(s00_axis.tdata[2*IQ_W-1:IQ_W]));
  end

  // S1 plus channel bookkeeping; tlast forces the next beat back to channel 0
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      ch_r    <= '0;
      hv_r    <= '0;
      v1_r    <= 1'b0;
      hv1_r   <= 1'b0;
      last1_r <= 1'b0;
      cur1_r  <= '0;
      prev1_r <= '0;
    end else begin
      if (acc_s) begin
        hv_r[ch_r] <= 1'b1;
        if (s00_axis.tlast || (ch_r == CH_W'(NUM_CH - 1))) begin
          ch_r <= '0;
        end else begin
          ch_r <= ch_r + CH_W'(1);
        end
      end
      if (en_s) begin
        v1_r    <= acc_s;
        cur1_r  <= cur_s;
        prev1_r <= hist_r[ch_r];
        hv1_r   <= hv_r[ch_r];
        last1_r <= s00_axis.tlast;
      end
    end
  end

  // History write; S1 above samples the entry before this update lands
  always_ff @(posedge s00_axis_aclk) begin
    if (acc_s) begin
      hist_r[ch_r] <= cur_s;
    end
  end

  cplx_conj_mult #(
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_mult (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .en        (en_s),
    .in_valid  (v1_r),
    .in_hv     (hv1_r),
    .in_last   (last1_r),
    .a         (cur1_r),
    .b         (prev1_r),
    .out_valid (m_valid_s),
    .out_last  (m00_axis.tlast),
    .out_data  (m00_axis.tdata),
    .out_strb  (m00_axis.tstrb)
  );

endmodule

// File: tb/tb_conj_demod_mc.sv
// Randomized scoreboard bench for conj_demod_mc against an arithmetic reference model.
module tb_conj_demod_mc;

  localparam int IQ_W   = 16;
  localparam int OUT_W  = 16;
  localparam int NUM_CH = 4;
  localparam int SHIFT  = 15;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  conj_demod_mc_if #(.DATA_W(2*IQ_W))  s_if ();
  conj_demod_mc_if #(.DATA_W(2*OUT_W)) m_if ();

  conj_demod_mc #(
    .IQ_W(IQ_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .SHIFT(SHIFT),
    .C_S00_AXIS_TDATA_WIDTH(2*IQ_W), .C_M00_AXIS_TDATA_WIDTH(2*OUT_W)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(aresetn),
    .s00_axis        (s_if),
    .m00_axis        (m_if)
  );

  typedef struct {
    logic [2*OUT_W-1:0] data;
    logic               last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_pct = 100;
  bit   stuck = 1'b0;

  // reference model state: per-channel previous sample and whether it exists
  longint mh_i [NUM_CH];
  longint mh_q [NUM_CH];
  bit     mhv  [NUM_CH];
  int     mch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] narrow(input longint x);
    longint v;
    v = (x + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef CONJ_DEMOD_SAT_EN
    if (v > (longint'(1) <<< (OUT_W - 1)) - 1) v = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (v < -(longint'(1) <<< (OUT_W - 1)))    v = -(longint'(1) <<< (OUT_W - 1));
`endif
    return v[OUT_W-1:0];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mh_i[k] = 0;
      mh_q[k] = 0;
      mhv[k]  = 1'b0;
    end
    mch = 0;
  endfunction

  function automatic void model_accept(input logic [IQ_W-1:0] i, input logic [IQ_W-1:0] q, input logic last);
    longint a, b, re, im;
    exp_t   e;
    a = longint'($signed(i));
    b = longint'($signed(q));
    re = a * mh_i[mch] + b * mh_q[mch];
    im = b * mh_i[mch] - a * mh_q[mch];
    e.data = mhv[mch] ? {narrow(im), narrow(re)} : '0;
    e.last = last;
    exp_q.push_back(e);
    mh_i[mch] = a;
    mh_q[mch] = b;
    mhv[mch]  = 1'b1;
    mch = last ? 0 : (mch + 1) % NUM_CH;
  endfunction

  // called at a falling edge; returns at a falling edge after the beat is taken
  task automatic send(input logic [IQ_W-1:0] i, input logic [IQ_W-1:0] q, input logic last);
    int tries = 0;
    bit done  = 1'b0;
    if (stuck) return;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {q, i};
    s_if.tlast  = last;
    s_if.tstrb  = '1;
    while (!done) begin
      #1;
      if (s_if.tready) begin
        model_accept(i, q, last);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 2000) begin
          checks++;
          errors++;
          stuck = 1'b1;
          $display("FAIL send_timeout: tready stayed %0b, required 1", s_if.tready);
          done = 1'b1;
        end
      end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_pulse();
    ready_pct = 0;
    aresetn   = 1'b0;
    @(negedge clk);
    #3;
    check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    aresetn   = 1'b1;
    ready_pct = 100;
  endtask

  // downstream ready generator
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      m_if.tready = ($urandom_range(99) < ready_pct);
    end
  end

  // monitor: compare each transferred beat, and require stability while stalled
  initial begin
    bit                 held = 1'b0;
    logic [2*OUT_W-1:0] hold_data = '0;
    logic               hold_last = 1'b0;
    exp_t               e;
    forever begin
      @(negedge clk);
      #2;
      if (!aresetn) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_tvalid", 64'(m_if.tvalid), 64'd1);
          check("stall_tdata", 64'(m_if.tdata), 64'(hold_data));
          check("stall_tlast", 64'(m_if.tlast), 64'(hold_last));
        end
        if (m_if.tvalid) begin
          check("out_tstrb", 64'(m_if.tstrb), 64'hF);
          if (m_if.tready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got %0h with no beat outstanding", m_if.tdata);
            end else begin
              e = exp_q.pop_front();
              check("out_tdata", 64'(m_if.tdata), 64'(e.data));
              check("out_tlast", 64'(m_if.tlast), 64'(e.last));
            end
          end else begin
            held      = 1'b1;
            hold_data = m_if.tdata;
            hold_last = m_if.tlast;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tstrb  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #3;
    check("reset_tvalid", 64'(m_if.tvalid), 64'd0);
    check("reset_tdata", 64'(m_if.tdata), 64'd0);
    check("reset_tstrb", 64'(m_if.tstrb), 64'd0);
    check("reset_tlast", 64'(m_if.tlast), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // single-channel behaviour: tlast on every beat pins the channel to 0
    send(16'd0, 16'd16384, 1'b1);
    send(16'd16384, 16'd0, 1'b1);
    // full-scale equal beats: re overflows the output range
    send(16'h8000, 16'h8000, 1'b1);
    send(16'h8000, 16'h8000, 1'b1);
    drain();

    // reset with two beats in flight, then history must be gone
    send(16'd100, 16'd200, 1'b0);
    send(16'd300, 16'hFFFB, 1'b0);
    reset_pulse();
    send(16'd1234, 16'hFCF7, 1'b0);
    drain();

    // four interleaved channels, three rounds
    reset_pulse();
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        send(16'(1000 * (k + 1)), 16'd0, 1'b0);
      end
    end
    // tlast mid-round returns the next beat to channel 0
    send(16'd11, 16'd22, 1'b0);
    send(16'd33, 16'd44, 1'b1);
    send(16'd55, 16'd66, 1'b0);
    drain();

    // random traffic with backpressure
    ready_pct = 30;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 70) begin
        send(16'($urandom), 16'($urandom), ($urandom_range(99) < 10));
      end else begin
        @(negedge clk);
      end
    end
    ready_pct = 100;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
